// File: rtl/cam_ctrl.sv
// Controller in front of an external CAM: it tracks which slots hold live keys
// and turns lookup/insert/delete/clear requests into CAM search and write cycles.
module cam_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int SEARCH_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  cam_start,
    output logic                  cam_write_enable,
    output logic [DATA_WIDTH-1:0] cam_din,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full
);

    // state  | meaning
    // IDLE   | waiting for a request; req_ready high
    // SEARCH | CAM search in flight; cam_start high for SEARCH_LAT+1 cycles
    // WRITE  | single-cycle CAM write into the chosen slot
    // RESP   | response held until rsp_ready
    typedef enum logic [1:0] {IDLE, SEARCH, WRITE, RESP} state_t;

    localparam int ENTRIES = 1 << ADDR_WIDTH;
    localparam int LAT_W   = (SEARCH_LAT > 0) ? $clog2(SEARCH_LAT + 1) : 1;

    localparam logic [ADDR_WIDTH:0] CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = ENTRIES[ADDR_WIDTH:0];

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_MISS = 2'b01;
    localparam logic [1:0] ST_DUP  = 2'b10;
    localparam logic [1:0] ST_FULL = 2'b11;

    state_t                  state_q, state_nxt;
    logic                    ready_en_q;
    logic [1:0]              op_q;
    logic [DATA_WIDTH-1:0]   key_q;
    logic [ADDR_WIDTH-1:0]   slot_q;
    logic [LAT_W-1:0]        lat_q;
    logic [ENTRIES-1:0]      valid_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic [1:0]              rsp_status_q;
    logic [ADDR_WIDTH-1:0]   rsp_addr_q;

    logic                    accept;
    logic                    qual_hit;
    logic                    need_write;
    logic [ADDR_WIDTH-1:0]   free_slot;
    logic [1:0]              srch_status;
    logic [ADDR_WIDTH-1:0]   srch_addr;
    logic [ADDR_WIDTH-1:0]   srch_slot;

    assign full   = (count_q == CNT_FULL);
    assign count  = count_q;
    assign accept = req_valid && req_ready;

    always_comb begin
        free_slot = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_slot = ADDR_WIDTH'(i);
        end
    end

    // A CAM hit on a slot we have retired is stale and only good for reuse.
    always_comb begin
        qual_hit    = cam_match && valid_q[cam_match_addr];
        need_write  = 1'b0;
        srch_status = ST_OK;
        srch_addr   = '0;
        srch_slot   = '0;
        if (op_q == OP_LOOKUP) begin
            srch_status = qual_hit ? ST_OK : ST_MISS;
            srch_addr   = qual_hit ? cam_match_addr : '0;
        end else if (qual_hit) begin
            srch_status = ST_DUP;
            srch_addr   = cam_match_addr;
        end else if (cam_match) begin
            need_write  = 1'b1;
            srch_slot   = cam_match_addr;
        end else if (full) begin
            srch_status = ST_FULL;
        end else begin
            need_write  = 1'b1;
            srch_slot   = free_slot;
        end
    end

    always_comb begin
        state_nxt        = state_q;
        req_ready        = ready_en_q && (state_q == IDLE);
        rsp_valid        = (state_q == RESP);
        cam_start        = (state_q == SEARCH);
        cam_write_enable = (state_q == WRITE);
        cam_din          = '0;
        cam_write_addr   = '0;
        rsp_status       = rsp_status_q;
        rsp_addr         = rsp_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_op == OP_LOOKUP || req_op == OP_INSERT) state_nxt = SEARCH;
                    else                                             state_nxt = RESP;
                end
            end
            SEARCH: begin
                cam_din = key_q;
                if (lat_q == '0) state_nxt = need_write ? WRITE : RESP;
            end
            WRITE: begin
                cam_din        = key_q;
                cam_write_addr = slot_q;
                state_nxt      = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ready_en_q   <= 1'b0;
            op_q         <= OP_LOOKUP;
            key_q        <= '0;
            slot_q       <= '0;
            lat_q        <= '0;
            valid_q      <= '0;
            count_q      <= '0;
            rsp_status_q <= ST_OK;
            rsp_addr_q   <= '0;
        end else begin
            state_q    <= state_nxt;
            ready_en_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= req_op;
                        key_q <= req_data;
                        lat_q <= LAT_W'(SEARCH_LAT);
                        if (req_op == OP_DELETE) begin
                            if (valid_q[req_addr]) begin
                                valid_q[req_addr] <= 1'b0;
                                count_q           <= count_q - CNT_ONE;
                                rsp_status_q      <= ST_OK;
                                rsp_addr_q        <= req_addr;
                            end else begin
                                rsp_status_q      <= ST_MISS;
                                rsp_addr_q        <= '0;
                            end
                        end else if (req_op == OP_CLEAR) begin
                            valid_q      <= '0;
                            count_q      <= '0;
                            rsp_status_q <= ST_OK;
                            rsp_addr_q   <= '0;
                        end
                    end
                end
                SEARCH: begin
                    if (lat_q != '0) begin
                        lat_q <= lat_q - LAT_W'(1);
                    end else begin
                        rsp_status_q <= srch_status;
                        rsp_addr_q   <= srch_addr;
                        slot_q       <= srch_slot;
                    end
                end
                WRITE: begin
                    valid_q[slot_q] <= 1'b1;
                    count_q         <= count_q + CNT_ONE;
                    rsp_status_q    <= ST_OK;
                    rsp_addr_q      <= slot_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl against a behavioural zero-filled CAM with one
// cycle of search latency; expected responses go through a scoreboard queue.
module tb_cam_ctrl;

    localparam int DW = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [DW-1:0] req_data = '0;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic          cam_start;
    logic          cam_write_enable;
    logic [DW-1:0] cam_din;
    logic [AW-1:0] cam_write_addr;
    logic          cam_match = 1'b0;
    logic [AW-1:0] cam_match_addr = '0;
    logic [AW:0]   count;
    logic          full;

    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;
    int excl_viol = 0;

    typedef struct {
        logic [1:0]    st;
        logic [AW-1:0] ad;
        int            lat;
        int            wr;
        int            cnt;
    } exp_t;
    exp_t sb[$];

    cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEARCH_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_addr(rsp_addr),
        .cam_start(cam_start), .cam_write_enable(cam_write_enable),
        .cam_din(cam_din), .cam_write_addr(cam_write_addr),
        .cam_match(cam_match), .cam_match_addr(cam_match_addr),
        .count(count), .full(full)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] cam_mem [4] = '{default: '0};

    function automatic logic [AW:0] cam_lookup(input logic [DW-1:0] key);
        logic [AW:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (cam_mem[i] == key) r = {1'b1, AW'(i)};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (cam_write_enable) begin
            cam_mem[cam_write_addr] <= cam_din;
            wr_pulses <= wr_pulses + 1;
        end
        if (cam_start) {cam_match, cam_match_addr} <= cam_lookup(cam_din);
        if (cam_start && cam_write_enable) excl_viol <= excl_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({req_ready, rsp_valid, rsp_status, rsp_addr, cam_start, cam_write_enable,
                    cam_din, cam_write_addr, count, full});
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 1);
    endtask

    task automatic do_req(input string tag, input logic [1:0] op, input logic [DW-1:0] d,
                          input logic [AW-1:0] a, input logic [1:0] est, input logic [AW-1:0] ead,
                          input int elat, input int ewr, input int ecnt, input int hold);
        exp_t e;
        int   lat;
        int   w0;
        wait_ready();
        sb.push_back('{st: est, ad: ead, lat: elat, wr: ewr, cnt: ecnt});
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_addr  = a;
        w0        = wr_pulses;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_status"}, 32'(rsp_status), 32'(e.st));
        check({tag, "_addr"}, 32'(rsp_addr), 32'(e.ad));
        check({tag, "_writes"}, 32'(wr_pulses - w0), 32'(e.wr));
        check({tag, "_count"}, 32'(count), 32'(e.cnt));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(rsp_valid), 1);
            check({tag, "_hold_status"}, 32'(rsp_status), 32'(e.st));
            check({tag, "_hold_addr"}, 32'(rsp_addr), 32'(e.ad));
            check({tag, "_hold_req_ready"}, 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_taken"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        int w0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs_vec(), 0);
        @(negedge clk) rst = 1'b1;
        #1;
        check("ready_before_edge", 32'(req_ready), 0);
        @(posedge clk); #1;
        check("ready_after_edge", 32'(req_ready), 1);

        do_req("lookup5_miss", 2'b00, 4'h5, 2'd0, 2'b01, 2'd0, 3, 0, 0, 0);
        do_req("insert5",      2'b01, 4'h5, 2'd0, 2'b00, 2'd0, 4, 1, 1, 0);
        do_req("insert5_dup",  2'b01, 4'h5, 2'd0, 2'b10, 2'd0, 3, 0, 1, 0);
        do_req("insertA",      2'b01, 4'hA, 2'd0, 2'b00, 2'd1, 4, 1, 2, 0);
        do_req("insert3",      2'b01, 4'h3, 2'd0, 2'b00, 2'd2, 4, 1, 3, 0);
        do_req("insertC",      2'b01, 4'hC, 2'd0, 2'b00, 2'd3, 4, 1, 4, 0);
        check("full_after_4", 32'(full), 1);
        do_req("insert7_full", 2'b01, 4'h7, 2'd0, 2'b11, 2'd0, 3, 0, 4, 0);
        do_req("delete1",      2'b10, 4'h0, 2'd1, 2'b00, 2'd1, 1, 0, 3, 0);
        check("full_after_delete", 32'(full), 0);
        do_req("lookupA_miss", 2'b00, 4'hA, 2'd0, 2'b01, 2'd0, 3, 0, 3, 0);
        do_req("insertA_stale",2'b01, 4'hA, 2'd0, 2'b00, 2'd1, 4, 1, 4, 0);
        do_req("delete1_again",2'b10, 4'h0, 2'd1, 2'b00, 2'd1, 1, 0, 3, 0);
        do_req("delete1_nf",   2'b10, 4'h0, 2'd1, 2'b01, 2'd0, 1, 0, 3, 0);
        do_req("lookup3_hold", 2'b00, 4'h3, 2'd0, 2'b00, 2'd2, 3, 0, 3, 5);
        do_req("clear",        2'b11, 4'h0, 2'd0, 2'b00, 2'd0, 1, 0, 0, 0);
        check("full_after_clear", 32'(full), 0);
        do_req("lookup5_clr",  2'b00, 4'h5, 2'd0, 2'b01, 2'd0, 3, 0, 0, 0);

        // Stale slot 0 still holds 0x5, so this insert heads for WRITE; reset lands there.
        wait_ready();
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_data  = 4'h5;
        w0        = wr_pulses;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midwrite_we", 32'(cam_write_enable), 1);
        check("midwrite_addr", 32'(cam_write_addr), 0);
        rst = 1'b0;
        #1;
        check("midwrite_reset_outputs", outs_vec(), 0);
        @(posedge clk); #1;
        check("midwrite_no_pulse", 32'(wr_pulses - w0), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        do_req("lookup5_after_rst", 2'b00, 4'h5, 2'd0, 2'b01, 2'd0, 3, 0, 0, 0);

        check("start_we_exclusive", 32'(excl_viol), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
